// File: rtl/input_controller.sv
// Player input front end: synchronises raw active-low keys, debounces each one,
// and arbitrates committed presses into single-cycle command pulses.
module input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] keyN,
  input  logic       inputLock,
  output logic       hitPulse,
  output logic       standPulse,
  output logic       dealPulse,
  output logic       newGamePulse,
  output logic [3:0] keyHeld
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } key_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       s1_q, s2_q;
  logic [3:0]       p;
  key_state_e       state_q [4];
  logic [CNT_W-1:0] cnt_q   [4];
  logic [3:0]       held_q;
  logic [3:0]       commit;
  logic [3:0]       accept;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       pulse_q, pulse_d;

  // Two-flop synchroniser; idle level (released) is 1.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= keyN;
      s2_q <= s1_q;
    end
  end

  assign p = ~s2_q;

  // Four independent debounce FSMs sharing one block.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
      held_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case (state_q[i])
          RELEASED: begin
            if (p[i]) begin
              state_q[i] <= PRESS_CHK;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          PRESS_CHK: begin
            if (!p[i]) begin
              state_q[i] <= RELEASED;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_q[i] <= PRESSED;
              cnt_q[i]   <= '0;
              held_q[i]  <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          PRESSED: begin
            if (!p[i]) begin
              state_q[i] <= RELEASE_CHK;
              cnt_q[i]   <= CNT_ONE;
            end
          end
          RELEASE_CHK: begin
            if (p[i]) begin
              state_q[i] <= PRESSED;
              cnt_q[i]   <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_q[i] <= RELEASED;
              cnt_q[i]   <= '0;
              held_q[i]  <= 1'b0;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            state_q[i] <= RELEASED;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    commit = '0;
    for (int i = 0; i < 4; i++) begin
      commit[i] = (state_q[i] == PRESS_CHK) && p[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  // Lock gates gameplay keys only; newGame always gets through.
  assign accept = commit & {1'b1, {3{~inputLock}}};

  // Fixed-priority arbiter over registered pending bits; new commits land after the clear.
  always_comb begin
    pulse_d   = '0;
    pending_d = pending_q;
    if (pending_q[3]) begin
      pulse_d   = 4'b1000;
      pending_d = '0;
    end else if (pending_q[2]) begin
      pulse_d      = 4'b0100;
      pending_d[2] = 1'b0;
    end else if (pending_q[1]) begin
      pulse_d      = 4'b0010;
      pending_d[1] = 1'b0;
    end else if (pending_q[0]) begin
      pulse_d      = 4'b0001;
      pending_d[0] = 1'b0;
    end
    pending_d = pending_d | accept;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      pending_q <= '0;
      pulse_q   <= '0;
    end else begin
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign hitPulse     = pulse_q[0];
  assign standPulse   = pulse_q[1];
  assign dealPulse    = pulse_q[2];
  assign newGamePulse = pulse_q[3];
  assign keyHeld      = held_q;

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with a short debounce window (4 cycles).
module tb_input_controller;

  logic       clk;
  logic       resetN;
  logic [3:0] keyN;
  logic       inputLock;
  logic       hitPulse, standPulse, dealPulse, newGamePulse;
  logic [3:0] keyHeld;

  int n_checks = 0;
  int n_fail   = 0;

  input_controller #(.DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .keyN         (keyN),
    .inputLock    (inputLock),
    .hitPulse     (hitPulse),
    .standPulse   (standPulse),
    .dealPulse    (dealPulse),
    .newGamePulse (newGamePulse),
    .keyHeld      (keyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pulses();
    return {newGamePulse, dealPulse, standPulse, hitPulse};
  endfunction

  // Runs n edges with keyN already applied; edge numbering starts at 1.
  // Pulse vector expected pv1 at edge pe1, pv2 at edge pe2, zero otherwise (pe=0: unused).
  // keyHeld expected hb before edge hf, hv from edge hf onward.
  task automatic run_phase(input string tag, input int n,
                           input int pe1, input logic [3:0] pv1,
                           input int pe2, input logic [3:0] pv2,
                           input int hf, input logic [3:0] hv, input logic [3:0] hb);
    logic [3:0] ep;
    for (int e = 1; e <= n; e++) begin
      tick();
      ep = 4'b0000;
      if (e == pe1) ep = pv1;
      if (e == pe2) ep = pv2;
      check($sformatf("%s pulse e%0d", tag, e), {28'd0, pulses()}, {28'd0, ep});
      check($sformatf("%s held e%0d", tag, e), {28'd0, keyHeld}, {28'd0, (e >= hf) ? hv : hb});
    end
  endtask

  logic [4:0] bnc;

  initial begin
    resetN    = 1'b0;
    keyN      = 4'b1111;
    inputLock = 1'b0;
    tick();
    tick();
    check("reset pulses", {28'd0, pulses()}, 32'd0);
    check("reset held", {28'd0, keyHeld}, 32'd0);
    resetN = 1'b1;
    run_phase("idle", 4, 0, 4'b0, 0, 4'b0, 1, 4'b0000, 4'b0000);

    // 1: single hit press, long hold, release
    keyN = 4'b1110;
    run_phase("t1", 60, 7, 4'b0001, 0, 4'b0, 6, 4'b0001, 4'b0000);
    keyN = 4'b1111;
    run_phase("t1rel", 10, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b0001);

    // 2: bounce 0,0,1,0,1 then stable low from edge 6
    bnc = 5'b10100;
    for (int e = 1; e <= 20; e++) begin
      keyN = {3'b111, (e <= 5) ? bnc[e-1] : 1'b0};
      tick();
      check($sformatf("t2 pulse e%0d", e), {28'd0, pulses()}, {28'd0, (e == 12) ? 4'b0001 : 4'b0000});
      check($sformatf("t2 held e%0d", e), {28'd0, keyHeld}, {28'd0, (e >= 11) ? 4'b0001 : 4'b0000});
    end
    keyN = 4'b1111;
    run_phase("t2rel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b0001);

    // 3: hit + newGame together; newGame wins and flushes hit
    keyN = 4'b0110;
    run_phase("t3", 20, 7, 4'b1000, 0, 4'b0, 6, 4'b1001, 4'b0000);
    keyN = 4'b1111;
    run_phase("t3rel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b1001);

    // 4: stand + deal together; deal first, stand next cycle
    keyN = 4'b1001;
    run_phase("t4", 15, 7, 4'b0100, 8, 4'b0010, 6, 4'b0110, 4'b0000);
    keyN = 4'b1111;
    run_phase("t4rel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b0110);

    // 5: lock drops stand but passes newGame; unlocked stand fires
    inputLock = 1'b1;
    keyN = 4'b1101;
    run_phase("t5lock", 12, 0, 4'b0, 0, 4'b0, 6, 4'b0010, 4'b0000);
    keyN = 4'b1111;
    run_phase("t5lrel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b0010);
    keyN = 4'b0111;
    run_phase("t5ng", 12, 7, 4'b1000, 0, 4'b0, 6, 4'b1000, 4'b0000);
    keyN = 4'b1111;
    run_phase("t5ngrel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b1000);
    inputLock = 1'b0;
    run_phase("t5idle", 4, 0, 4'b0, 0, 4'b0, 1, 4'b0000, 4'b0000);
    keyN = 4'b1101;
    run_phase("t5st", 12, 7, 4'b0010, 0, 4'b0, 6, 4'b0010, 4'b0000);
    keyN = 4'b1111;
    run_phase("t5strel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b0010);

    // 6: reset mid-debounce with key held; press restarts from scratch
    keyN = 4'b1110;
    run_phase("t6a", 3, 0, 4'b0, 0, 4'b0, 1, 4'b0000, 4'b0000);
    resetN = 1'b0;
    tick();
    check("t6 rst pulses", {28'd0, pulses()}, 32'd0);
    check("t6 rst held", {28'd0, keyHeld}, 32'd0);
    resetN = 1'b1;
    run_phase("t6b", 12, 7, 4'b0001, 0, 4'b0, 6, 4'b0001, 4'b0000);
    keyN = 4'b1111;
    run_phase("t6rel", 8, 0, 4'b0, 0, 4'b0, 6, 4'b0000, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
